// File: rtl/output_sram_arbiter.sv
// Output SRAM write arbiter: round-robin selection among NUM_REQ vertex-buffer
// bank requesters into a one-entry output stage that drives the SRAM write port.
// Optional feature: define OSRAM_ARB_STATS_EN to add a saturating 16-bit
// write_count output counting writes accepted by the SRAM.
module output_sram_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic                      sram_wen,
    output logic [ADDR_W-1:0]         sram_addr,
    output logic [DATA_W-1:0]         sram_wdata,
    input  logic                      sram_ready,
    output logic                      idle
`ifdef OSRAM_ARB_STATS_EN
    ,
    output logic [15:0]               write_count
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic                can_accept;
    logic                found;
    logic                do_grant;
    logic [PTR_W-1:0]    winner;
    logic [PTR_W:0]      sum;
    logic [PTR_W-1:0]    idx;

    // Round-robin search starting at rr_ptr, wrapping past the last bank to bank 0.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Grant is combinational; the stage can refill in the same cycle it drains.
    always_comb begin
        can_accept = (state_q == EMPTY) || sram_ready;
        do_grant   = reset && can_accept && found;
        req_grant  = '0;
        if (do_grant) begin
            req_grant[winner] = 1'b1;
        end
    end

    // Next state of the output stage and the round-robin pointer.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (do_grant) begin
            state_d  = FULL;
            addr_d   = req_addr[int'(winner)*ADDR_W +: ADDR_W];
            data_d   = req_data[int'(winner)*DATA_W +: DATA_W];
            rr_ptr_d = (winner == PTR_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
        end else if ((state_q == FULL) && sram_ready) begin
            state_d = EMPTY;
        end
    end

    // State register; a reset drops any pending entry without writing it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= EMPTY;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Output stage address/data, cleared on reset so the SRAM port starts at zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q <= '0;
            data_q <= '0;
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign sram_wen   = (state_q == FULL);
    assign sram_addr  = addr_q;
    assign sram_wdata = data_q;
    assign idle       = (state_q == EMPTY) && !(|req_valid);

`ifdef OSRAM_ARB_STATS_EN
    logic [15:0] write_count_q, write_count_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Count SRAM-accepted writes, sticking at the maximum value.
    always_comb begin
        write_count_d = write_count_q;
        if ((state_q == FULL) && sram_ready) begin
            write_count_d = sat_inc16(write_count_q);
        end
    end

    // Write counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            write_count_q <= '0;
        end else begin
            write_count_q <= write_count_d;
        end
    end

    assign write_count = write_count_q;
`endif

endmodule

// File: doc/output_sram_arbiter.md
OUTPUT_SRAM_ARBITER -- requirements
Module: output_sram_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4 (`Num_Vertex_Unit), number of vertex-buffer bank requesters.
REQ-002 Parameter ADDR_W, default 8, output SRAM word address width.
REQ-003 Parameter DATA_W, default 64, output SRAM word data width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-bank write request valid.
REQ-007 req_addr  input  NUM_REQ*ADDR_W  per-bank write address, bank i in slice [i*ADDR_W +: ADDR_W].
REQ-008 req_data  input  NUM_REQ*DATA_W  per-bank write data, bank i in slice [i*DATA_W +: DATA_W].
REQ-009 req_grant  output  NUM_REQ  one-hot-or-zero; bit i high means bank i's request is accepted this cycle.
REQ-010 sram_wen  output  1  write strobe to output SRAM.
REQ-011 sram_addr  output  ADDR_W  write address to output SRAM.
REQ-012 sram_wdata  output  DATA_W  write data to output SRAM.
REQ-013 sram_ready  input  1  SRAM accepts the presented write at this edge when high.
REQ-014 idle  output  1  high when no write is pending in the output stage and no req_valid is high.

Function
REQ-015 Output stage is a one-entry register with states EMPTY and FULL; sram_wen equals (state == FULL).
REQ-016 Stage can accept when EMPTY, or FULL with sram_ready high (same-cycle drain and refill).
REQ-017 Arbitration: when stage can accept and any req_valid is high, grant exactly one bank, chosen round-robin starting at rr_ptr, searching upward with wrap from NUM_REQ-1 to 0.
REQ-018 req_grant is combinational in the acceptance cycle; zero when stage cannot accept or no request is valid.
REQ-019 At the edge ending the grant cycle, winner's addr/data load into the stage, state becomes FULL, rr_ptr becomes winner+1 modulo NUM_REQ.
REQ-020 FULL with sram_ready high and no new grant: state becomes EMPTY at the edge.
REQ-021 FULL with sram_ready low: stage, sram_addr, sram_wdata hold; req_grant is zero; rr_ptr holds.
REQ-022 Write latency: granted request appears on sram_wen/addr/wdata exactly one cycle after grant.
REQ-023 Sustained throughput: one write per cycle when sram_ready stays high.
REQ-024 Requesters hold req_valid/addr/data stable until granted; the arbiter does not sample non-granted banks.
REQ-025 Fairness: with all banks continuously valid and sram_ready high, each bank is granted once every NUM_REQ cycles.
REQ-026 A request deasserted before grant is dropped without side effects; rr_ptr is unaffected.

Reset
REQ-027 With reset low at a rising edge: state EMPTY, rr_ptr 0, sram_wen 0, sram_addr 0, sram_wdata 0.
REQ-028 req_grant is forced to zero while reset is low.
REQ-029 Reset mid-operation discards any pending FULL entry; no write is issued for it.
REQ-030 idle is 1 after reset if all req_valid are low.

Configuration
REQ-031 Macro OSRAM_ARB_STATS_EN, when defined, adds output write_count (16 bits): count of writes accepted by SRAM (sram_wen & sram_ready), reset to 0, saturating at 16'hFFFF.
REQ-032 Without OSRAM_ARB_STATS_EN the write_count port and counter are absent; all other behaviour is identical.

Verification
REQ-033 Reset low 2 cycles, then req_valid=0 -> sram_wen=0, req_grant=0, idle=1, sram_addr=0.
REQ-034 Bank 2 valid, addr 8'h15, data 64'hA5, sram_ready=1 -> req_grant=4'b0100 in cycle T; sram_wen=1, sram_addr=8'h15, sram_wdata=64'hA5 in T+1; stage EMPTY in T+2.
REQ-035 All 4 banks valid continuously, sram_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; sram_wen high every cycle from second cycle.
REQ-036 Stage FULL, sram_ready=0 for 3 cycles with banks 1,3 valid -> req_grant=0, sram outputs held; on sram_ready=1, bank 1 granted in that same cycle, then bank 3.
REQ-037 Reset asserted while FULL with sram_ready=0 -> next cycle sram_wen=0, rr_ptr=0; bank 0 and bank 3 valid afterwards -> bank 0 granted first.
REQ-038 With OSRAM_ARB_STATS_EN, 5 writes accepted -> write_count=5; preload 16'hFFFF then 1 more write -> write_count stays 16'hFFFF.
